// File: rtl/bbp_update_queue_pkg.sv
// Shared bimodal branch-predictor definitions: table index geometry and the
// PC-to-index mapping used by both the fetch lookup and the update path.
package bbp_update_queue_pkg;

  localparam int BBP_IDX_W   = 10;
  localparam int BBP_IDX_LSB = 2;

  typedef logic [BBP_IDX_W-1:0] bbp_idx_t;

  // One queued training update: table index plus resolved outcome.
  typedef struct packed {
    bbp_idx_t idx;
    logic     taken;
  } bbp_upd_t;

  localparam int BBP_UPD_W = $bits(bbp_upd_t);

  function automatic bbp_idx_t pc_to_bbp_idx(input logic [31:0] pc);
    return pc[BBP_IDX_LSB +: BBP_IDX_W];
  endfunction

endpackage

// File: rtl/bbp_upd_fifo.sv
// Small synchronous FIFO holding pending predictor updates.
// Power-of-two depth; pointers wrap naturally, count carries one extra bit.
module bbp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == cnt_t'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; count/pointers decide validity,
  // so resetting the array would only add reset fan-out for no behaviour.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bbp_update_queue.sv
// Branch-resolution update queue: buffers resolved branches and drains them,
// one per cycle, into the bimodal table write port; keeps branch statistics.
module bbp_update_queue
  import bbp_update_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [PC_W-1:0]      res_pc,
  input  logic                 res_taken,
  input  logic                 res_pred_taken,
  input  logic                 upd_hold,
  output logic                 upd_write,
  output logic [BBP_IDX_W-1:0] upd_address,
  output logic                 upd_data,
  output logic                 pending,
  input  logic                 clear_stats,
  output logic [CNT_W-1:0]     branch_count,
  output logic [CNT_W-1:0]     mispredict_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               PTR_W   = $clog2(DEPTH);

  bbp_upd_t         enq_entry;
  bbp_upd_t         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W:0]   fifo_count;
  logic             accept;
  logic             dequeue;

  assign enq_entry.idx   = pc_to_bbp_idx(32'(res_pc));
  assign enq_entry.taken = res_taken;

  // Ready looks only at the current occupancy, so a same-cycle drain never
  // creates room for an accept in that cycle.
  assign res_ready = !fifo_full;
  assign accept    = res_valid && res_ready;
  assign dequeue   = !fifo_empty && !upd_hold;
  assign pending   = !fifo_empty || upd_write;

  bbp_upd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BBP_UPD_W)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (accept),
    .push_data (enq_entry),
    .pop       (dequeue),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Address/data keep the last written update between strobes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      upd_write   <= 1'b0;
      upd_address <= '0;
      upd_data    <= 1'b0;
    end else begin
      upd_write <= dequeue;
      if (dequeue) begin
        upd_address <= head.idx;
        upd_data    <= head.taken;
      end
    end
  end

  // A clear in the same cycle as an accept wins; that branch goes uncounted.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (clear_stats) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (accept) begin
      if (branch_count != CNT_MAX) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if ((res_taken != res_pred_taken) && (mispredict_count != CNT_MAX)) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bbp_update_queue.sv
// Directed bench for bbp_update_queue: checks reset, latency, back-pressure,
// FIFO ordering, statistics saturation/clear and mid-drain reset.
module tb_bbp_update_queue;
  import bbp_update_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  // Narrow statistics counters so saturation is reachable in a short run.
  localparam int CNT_W = 8;

  logic                 CLK = 1'b0;
  logic                 RESET = 1'b0;
  logic                 res_valid = 1'b0;
  logic                 res_ready;
  logic [PC_W-1:0]      res_pc = '0;
  logic                 res_taken = 1'b0;
  logic                 res_pred_taken = 1'b0;
  logic                 upd_hold = 1'b0;
  logic                 upd_write;
  logic [BBP_IDX_W-1:0] upd_address;
  logic                 upd_data;
  logic                 pending;
  logic                 clear_stats = 1'b0;
  logic [CNT_W-1:0]     branch_count;
  logic [CNT_W-1:0]     mispredict_count;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int w0;
  logic stream_done = 1'b0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_e;
  logic [CNT_W-1:0] exp_br = '0;
  logic [CNT_W-1:0] exp_mis = '0;

  always #5 CLK = ~CLK;

  bbp_update_queue #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_pc           (res_pc),
    .res_taken        (res_taken),
    .res_pred_taken   (res_pred_taken),
    .upd_hold         (upd_hold),
    .upd_write        (upd_write),
    .upd_address      (upd_address),
    .upd_data         (upd_data),
    .pending          (pending),
    .clear_stats      (clear_stats),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Present one branch, wait (bounded) for ready, record the expected update.
  task automatic push(input logic [31:0] pc, input logic t, input logic p);
    int waited;
    waited = 0;
    res_pc = pc;
    res_taken = t;
    res_pred_taken = p;
    res_valid = 1'b1;
    while (!res_ready && waited < 64) begin
      tick();
      waited++;
    end
    if (!res_ready) begin
      check("push_ready_timeout", {31'b0, res_ready}, 32'd1);
    end else begin
      exp_q.push_back({pc[11:2], t});
      if (clear_stats) begin
        exp_br  = '0;
        exp_mis = '0;
      end else begin
        if (exp_br != '1) exp_br++;
        if (t != p && exp_mis != '1) exp_mis++;
      end
    end
    tick();
    res_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while ((pending || exp_q.size() != 0) && w < 200) begin
      tick();
      w++;
    end
    check({tag, "_pending_clear"}, {31'b0, pending}, 32'd0);
    check({tag, "_all_written"}, exp_q.size(), 32'd0);
  endtask

  // Write monitor: every strobe must match the head of the expected order.
  always @(negedge CLK) begin
    if (RESET) begin
      check("fifo_count_le_depth", {31'b0, (dut.u_fifo.count <= 3'd4)}, 32'd1);
      if (upd_write) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_write", {31'b0, upd_write}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_address", {22'b0, upd_address}, {22'b0, mon_e[10:1]});
          check("wr_data", {31'b0, upd_data}, {31'b0, mon_e[0]});
        end
      end
    end
  end

  initial begin
    // Reset and idle.
    tick(2);
    check("rst_ready", res_ready, 1);
    check("rst_pending", pending, 0);
    check("rst_write", upd_write, 0);
    check("rst_branch_count", branch_count, 0);
    check("rst_mispredict_count", mispredict_count, 0);
    @(negedge CLK);
    RESET = 1'b1;
    tick();

    // Single branch: pc 0x1234 -> index 0x08D, taken, mispredicted.
    push(32'h0000_1234, 1'b1, 1'b0);
    check("single_no_early_write", upd_write, 0);
    check("single_pending", pending, 1);
    check("single_branch_count", branch_count, 1);
    check("single_mispredict_count", mispredict_count, 1);
    tick();
    check("single_write", upd_write, 1);
    check("single_address", upd_address, 10'h08D);
    check("single_data", upd_data, 1);
    tick();
    check("single_write_done", upd_write, 0);
    check("single_pending_done", pending, 0);

    // Fill with hold: 4 accepted, 5th back-pressured until the drain starts.
    upd_hold = 1'b1;
    w0 = wr_cnt;
    push(32'h0000_0100, 1'b1, 1'b1);
    push(32'h0000_0204, 1'b0, 1'b1);
    push(32'h0000_0308, 1'b1, 1'b0);
    push(32'h0000_040C, 1'b0, 1'b0);
    check("fill_not_ready", res_ready, 0);
    res_pc = 32'h0000_0510;
    res_taken = 1'b1;
    res_pred_taken = 1'b1;
    res_valid = 1'b1;
    tick(2);
    check("fill_still_not_ready", res_ready, 0);
    check("fill_no_write_on_hold", wr_cnt - w0, 0);
    check("fill_pending_on_hold", pending, 1);
    upd_hold = 1'b0;
    push(32'h0000_0510, 1'b1, 1'b1);
    tick(4);
    check("fill_consecutive_writes", wr_cnt - w0, 5);
    check("fill_write_done", upd_write, 0);
    check("fill_pending_done", pending, 0);
    check("fill_branch_count", branch_count, 6);
    check("fill_mispredict_count", mispredict_count, 3);

    // Same index three times: three separate strobes to 0x010, data 1,1,0.
    w0 = wr_cnt;
    push(32'h0000_0040, 1'b1, 1'b1);
    push(32'h0000_0040, 1'b1, 1'b0);
    push(32'h0000_0040, 1'b0, 1'b0);
    check("same_idx_last_address", upd_address, 10'h010);
    wait_drain("same_idx");
    check("same_idx_write_count", wr_cnt - w0, 3);
    check("same_idx_last_data", upd_data, 0);

    // Stream of 20 with hold toggling every 3 cycles.
    w0 = wr_cnt;
    stream_done = 1'b0;
    fork
      begin
        while (!stream_done) begin
          tick(3);
          upd_hold = ~upd_hold;
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          push(32'h0000_1000 + 32'(i * 36), i[0] ^ i[2], i[1]);
        end
        stream_done = 1'b1;
      end
    join
    upd_hold = 1'b0;
    wait_drain("stream");
    check("stream_write_count", wr_cnt - w0, 20);
    check("stream_branch_count", branch_count, exp_br);
    check("stream_mispredict_count", mispredict_count, exp_mis);

    // Saturation: 260 further mispredicted branches pin both counters at max.
    for (int i = 0; i < 260; i++) begin
      push(32'(i * 4), 1'b1, 1'b0);
    end
    check("sat_branch_count", branch_count, 8'hFF);
    check("sat_mispredict_count", mispredict_count, 8'hFF);
    push(32'h0000_0ABC, 1'b0, 1'b1);
    check("sat_branch_hold", branch_count, 8'hFF);
    check("sat_mispredict_hold", mispredict_count, 8'hFF);
    wait_drain("sat");

    // Clear together with an accept: clear wins, branch is not counted.
    clear_stats = 1'b1;
    push(32'h0000_0080, 1'b1, 1'b0);
    clear_stats = 1'b0;
    check("clear_branch_count", branch_count, 0);
    check("clear_mispredict_count", mispredict_count, 0);
    push(32'h0000_0084, 1'b0, 1'b1);
    check("post_clear_branch_count", branch_count, 1);
    check("post_clear_mispredict_count", mispredict_count, 1);
    wait_drain("clear");

    // Reset mid-drain with entries queued and a write in flight.
    upd_hold = 1'b1;
    push(32'h0000_0300, 1'b1, 1'b1);
    push(32'h0000_0304, 1'b0, 1'b0);
    push(32'h0000_0308, 1'b1, 1'b0);
    upd_hold = 1'b0;
    tick();
    check("mid_write_in_flight", upd_write, 1);
    #2;
    RESET = 1'b0;
    #1;
    exp_q.delete();
    exp_br  = '0;
    exp_mis = '0;
    check("mid_rst_write", upd_write, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_ready", res_ready, 1);
    check("mid_rst_address", upd_address, 0);
    check("mid_rst_data", upd_data, 0);
    check("mid_rst_branch_count", branch_count, 0);
    check("mid_rst_mispredict_count", mispredict_count, 0);
    tick(2);
    @(negedge CLK);
    RESET = 1'b1;
    w0 = wr_cnt;
    tick(6);
    check("post_rst_no_write", wr_cnt - w0, 0);
    check("post_rst_pending", pending, 0);
    check("post_rst_write", upd_write, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
